// File: rtl/rr_alu_sequencer.sv
// Control sequencer for register-to-register ALU instructions.
// It latches one instruction per start and issues data_path strobes from registered outputs.
module rr_alu_sequencer #(
  parameter int NUM_REGS = 16
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                start,
  input  logic [31:0]         IR,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic                Yin,
  output logic                ZHighin,
  output logic                Zlowin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [4:0]          op,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE, S_T_Y, S_T_ALU, S_T_WRL, S_T_WRH, S_FIN, S_ERR
  } state_t;

  localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [16:0]         ir_q, ir_d;   // IR[31:15]: opcode, Ra, Rb, Rc
  logic [NUM_REGS-1:0] rout_q, rout_d, rin_q, rin_d;
  logic                yin_q, yin_d, zhighin_q, zhighin_d, zlowin_q, zlowin_d;
  logic                zlowout_q, zlowout_d, zhighout_q, zhighout_d;
  logic                hiin_q, hiin_d, loin_q, loin_d;
  logic [4:0]          op_q, op_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;

  // Low instruction bits carry no meaning for this block.
  logic ir_low_unused;
  assign ir_low_unused = ^IR[14:0];

  function automatic logic is_wide(input logic [4:0] opc);
    return (opc == 5'd15) || (opc == 5'd16);
  endfunction

  function automatic logic is_illegal(input logic [4:0] opc);
    return opc[4] & opc[3];
  endfunction

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ir_d    = IR[31:15];
          state_d = is_illegal(IR[31:27]) ? S_ERR : S_T_Y;
        end
      end
      S_T_Y:   state_d = S_T_ALU;
      S_T_ALU: state_d = S_T_WRL;
      S_T_WRL: state_d = is_wide(ir_q[16:12]) ? S_T_WRH : S_FIN;
      S_T_WRH: state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are ready as registers.
  always_comb begin
    rout_d     = '0;
    rin_d      = '0;
    yin_d      = 1'b0;
    zhighin_d  = 1'b0;
    zlowin_d   = 1'b0;
    zlowout_d  = 1'b0;
    zhighout_d = 1'b0;
    hiin_d     = 1'b0;
    loin_d     = 1'b0;
    op_d       = 5'd0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_T_Y: begin
        rout_d = ONE << ir_d[7:4];
        yin_d  = 1'b1;
      end
      S_T_ALU: begin
        rout_d    = ONE << ir_d[3:0];
        zhighin_d = 1'b1;
        zlowin_d  = 1'b1;
        op_d      = ir_d[16:12];
      end
      S_T_WRL: begin
        zlowout_d = 1'b1;
        if (is_wide(ir_d[16:12])) loin_d = 1'b1;
        else                      rin_d  = ONE << ir_d[11:8];
      end
      S_T_WRH: begin
        zhighout_d = 1'b1;
        hiin_d     = 1'b1;
      end
      S_FIN: done_d = 1'b1;
      S_ERR: begin
        done_d = 1'b1;
        err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      rout_q     <= '0;
      rin_q      <= '0;
      yin_q      <= 1'b0;
      zhighin_q  <= 1'b0;
      zlowin_q   <= 1'b0;
      zlowout_q  <= 1'b0;
      zhighout_q <= 1'b0;
      hiin_q     <= 1'b0;
      loin_q     <= 1'b0;
      op_q       <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      rout_q     <= rout_d;
      rin_q      <= rin_d;
      yin_q      <= yin_d;
      zhighin_q  <= zhighin_d;
      zlowin_q   <= zlowin_d;
      zlowout_q  <= zlowout_d;
      zhighout_q <= zhighout_d;
      hiin_q     <= hiin_d;
      loin_q     <= loin_d;
      op_q       <= op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign Rout     = rout_q;
  assign Rin      = rin_q;
  assign Yin      = yin_q;
  assign ZHighin  = zhighin_q;
  assign Zlowin   = zlowin_q;
  assign Zlowout  = zlowout_q;
  assign Zhighout = zhighout_q;
  assign HIin     = hiin_q;
  assign LOin     = loin_q;
  assign op       = op_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rr_alu_sequencer.sv
// Directed, table-driven bench for rr_alu_sequencer.
// Each table row is one clock: inputs applied, then all outputs compared.
module tb_rr_alu_sequencer;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] IR    = 32'd0;
  logic [15:0] Rout, Rin;
  logic        Yin, ZHighin, Zlowin, Zlowout, Zhighout, HIin, LOin;
  logic [4:0]  op;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  rr_alu_sequencer #(.NUM_REGS(16)) dut (
    .Clock(Clock), .clear(clear), .start(start), .IR(IR),
    .Rout(Rout), .Rin(Rin), .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .op(op), .busy(busy), .done(done), .err(err)
  );

  always #5 Clock = ~Clock;

  // Strobe order: {Yin, ZHighin, Zlowin, Zlowout, Zhighout, HIin, LOin}
  localparam logic [6:0] Y   = 7'b1000000;
  localparam logic [6:0] ZZ  = 7'b0110000;
  localparam logic [6:0] ZLO = 7'b0001000;
  localparam logic [6:0] ZHO = 7'b0000100;
  localparam logic [6:0] HI  = 7'b0000010;
  localparam logic [6:0] LO  = 7'b0000001;
  // Status order: {busy, done, err}
  localparam logic [2:0] B   = 3'b100;
  localparam logic [2:0] DN  = 3'b110;
  localparam logic [2:0] DE  = 3'b111;
  localparam logic [2:0] IDL = 3'b000;

  localparam logic [31:0] I_ADD = 32'h00918000; // add R1,R2,R3
  localparam logic [31:0] I_MUL = 32'h78228000; // op15 Rb=4 Rc=5
  localparam logic [31:0] I_DIV = 32'h83FF8000; // op16 Ra=7 Rb=15 Rc=15
  localparam logic [31:0] I_SUB = 32'hB8000000; // op23 all regs 0
  localparam logic [31:0] I_14  = 32'h77FF0000; // op14 Ra=15 Rb=15 Rc=14
  localparam logic [31:0] I_17  = 32'h89188000; // op17 Ra=2 Rb=3 Rc=1
  localparam logic [31:0] I_ILL = 32'hF8000000;
  localparam logic [31:0] I_24  = 32'hC0918000;

  typedef struct packed {
    logic        st;
    logic [31:0] ir;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [6:0]  strb;
    logic [4:0]  op;
    logic [2:0]  bde;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic [31:0] ir, input logic [15:0] ro,
                     input logic [15:0] ri, input logic [6:0] s, input logic [4:0] o,
                     input logic [2:0] b);
    vec_t v;
    v.st = st; v.ir = ir; v.rout = ro; v.rin = ri; v.strb = s; v.op = o; v.bde = b;
    vecs.push_back(v);
  endtask

  function automatic logic [46:0] outs();
    return {Rout, Rin, Yin, ZHighin, Zlowin, Zlowout, Zhighout, HIin, LOin, op, busy, done, err};
  endfunction

  task automatic check(input string name, input logic [46:0] got, input logic [46:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    logic seen_done;
    logic ok;
    logic exp_done, exp_busy;

    // Add R1,R2,R3
    add(1, I_ADD, 16'h0004, 16'h0000, Y,   5'd0,  B);
    add(0, I_ADD, 16'h0008, 16'h0000, ZZ,  5'd0,  B);
    add(0, I_ADD, 16'h0000, 16'h0002, ZLO, 5'd0,  B);
    add(0, I_ADD, 16'h0000, 16'h0000, 7'd0, 5'd0, DN);
    add(0, I_ADD, 16'h0000, 16'h0000, 7'd0, 5'd0, IDL);
    // Mul: LO then HI, Rin never set
    add(1, I_MUL, 16'h0010, 16'h0000, Y,        5'd0,  B);
    add(0, I_MUL, 16'h0020, 16'h0000, ZZ,       5'd15, B);
    add(0, I_MUL, 16'h0000, 16'h0000, ZLO | LO, 5'd0,  B);
    add(0, I_MUL, 16'h0000, 16'h0000, ZHO | HI, 5'd0,  B);
    add(0, I_MUL, 16'h0000, 16'h0000, 7'd0,     5'd0,  DN);
    add(0, I_MUL, 16'h0000, 16'h0000, 7'd0,     5'd0,  IDL);
    // Div with Rb==Rc==15
    add(1, I_DIV, 16'h8000, 16'h0000, Y,        5'd0,  B);
    add(0, I_DIV, 16'h8000, 16'h0000, ZZ,       5'd16, B);
    add(0, I_DIV, 16'h0000, 16'h0000, ZLO | LO, 5'd0,  B);
    add(0, I_DIV, 16'h0000, 16'h0000, ZHO | HI, 5'd0,  B);
    add(0, I_DIV, 16'h0000, 16'h0000, 7'd0,     5'd0,  DN);
    add(0, I_DIV, 16'h0000, 16'h0000, 7'd0,     5'd0,  IDL);
    // Opcode 23, all register fields 0
    add(1, I_SUB, 16'h0001, 16'h0000, Y,    5'd0,  B);
    add(0, I_SUB, 16'h0001, 16'h0000, ZZ,   5'd23, B);
    add(0, I_SUB, 16'h0000, 16'h0001, ZLO,  5'd0,  B);
    add(0, I_SUB, 16'h0000, 16'h0000, 7'd0, 5'd0,  DN);
    add(0, I_SUB, 16'h0000, 16'h0000, 7'd0, 5'd0,  IDL);
    // Opcode 14, top registers
    add(1, I_14, 16'h8000, 16'h0000, Y,    5'd0,  B);
    add(0, I_14, 16'h4000, 16'h0000, ZZ,   5'd14, B);
    add(0, I_14, 16'h0000, 16'h8000, ZLO,  5'd0,  B);
    add(0, I_14, 16'h0000, 16'h0000, 7'd0, 5'd0,  DN);
    add(0, I_14, 16'h0000, 16'h0000, 7'd0, 5'd0,  IDL);
    // Opcode 17; IR garbled during T_Y, start pulsed with a mul during cycle 2
    add(1, I_17,         16'h0008, 16'h0000, Y,    5'd0,  B);
    add(0, 32'hFFFFFFFF, 16'h0002, 16'h0000, ZZ,   5'd17, B);
    add(1, I_MUL,        16'h0000, 16'h0004, ZLO,  5'd0,  B);
    add(0, I_MUL,        16'h0000, 16'h0000, 7'd0, 5'd0,  DN);
    add(0, I_MUL,        16'h0000, 16'h0000, 7'd0, 5'd0,  IDL);
    add(0, I_MUL,        16'h0000, 16'h0000, 7'd0, 5'd0,  IDL);
    // Illegal opcodes 31 and 24
    add(1, I_ILL, 16'h0000, 16'h0000, 7'd0, 5'd0, DE);
    add(0, I_ILL, 16'h0000, 16'h0000, 7'd0, 5'd0, IDL);
    add(1, I_24,  16'h0000, 16'h0000, 7'd0, 5'd0, DE);
    add(0, I_24,  16'h0000, 16'h0000, 7'd0, 5'd0, IDL);

    // Reset state
    #1 clear = 1'b0;
    #2 check("reset_outputs", outs(), 47'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock) clear = 1'b1;

    foreach (vecs[i]) begin
      start = vecs[i].st;
      IR    = vecs[i].ir;
      @(posedge Clock);
      #1;
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].rout, vecs[i].rin, vecs[i].strb, vecs[i].op, vecs[i].bde});
      $display("vec%0d ir=%h start=%0b outs=%h", i, vecs[i].ir, vecs[i].st, outs());
    end

    // Back-to-back adds with start held high
    start = 1'b1;
    IR    = I_ADD;
    for (int c = 1; c <= 15; c++) begin
      @(posedge Clock);
      #1;
      exp_done = (c == 4) || (c == 9) || (c == 14);
      exp_busy = !((c == 5) || (c == 10) || (c == 15));
      check($sformatf("b2b_status_c%0d", c), {44'd0, busy, done, err},
            {44'd0, exp_busy, exp_done, 1'b0});
      ok = $onehot0(Rout) && $onehot0(Rin) && !((|Rout) && (|Rin));
      if (busy && !done)
        ok = ok && ($countones({|Rout, Zlowout, Zhighout}) == 1);
      check($sformatf("b2b_onehot_c%0d", c), {46'd0, ok}, 47'd1);
      $display("b2b c%0d busy=%0b done=%0b Rout=%h Rin=%h", c, busy, done, Rout, Rin);
    end
    start = 1'b0;

    // Reset mid-T_ALU of an add
    @(posedge Clock);
    #1 start = 1'b1;
    @(posedge Clock);
    #1 start = 1'b0;
    @(posedge Clock);
    #1 check("pre_reset_t_alu", outs(), {16'h0008, 16'h0000, ZZ, 5'd0, B});
    #2 clear = 1'b0;
    #1 check("async_reset_outputs", outs(), 47'd0);
    @(posedge Clock);
    #1 check("held_reset_outputs", outs(), 47'd0);
    @(negedge Clock) clear = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clock);
      #1 if (done || busy) seen_done = 1'b1;
    end
    check("no_done_after_abort", {46'd0, seen_done}, 47'd0);
    check("idle_after_abort", outs(), 47'd0);
    $display("reset abort busy=%0b done=%0b", busy, done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
